// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, capacity and header width.
package loader_pkg;
  localparam int MAX_WORDS = 1024;
  localparam int HDR_WIDTH = 16;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    WRITE  = 3'd3,
    RUN    = 3'd4,
    ERR    = 3'd5
  } state_t;
endpackage

// File: rtl/insn_word_packer.sv
// Assembles four accepted bytes, least significant first, into one 32-bit instruction word.
module insn_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);
  logic [1:0]  cnt_q;
  logic [23:0] sr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else if (byte_en_i) begin
      sr_q  <= {byte_i, sr_q[23:8]};
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Word is presented combinationally with the fourth byte so the loader can register it.
  assign word_done_o = byte_en_i && (cnt_q == 2'd3);
  assign word_o      = {byte_i, sr_q};
endmodule

// File: rtl/insn_loader.sv
// Byte-stream program loader: length header, then words written to instruction memory,
// then the CPU is released from reset until it signals ebreak.
module insn_loader
  import loader_pkg::*;
#(
  parameter int MAX_WORDS  = loader_pkg::MAX_WORDS,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  input  logic                  ebreak_i,
  output logic                  insn_mem_wen_o,
  output logic [ADDR_WIDTH-1:0] insn_mem_waddr_o,
  output logic [31:0]           insn_o,
  output logic                  cpu_rstn_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic [2:0]            dbg_state_o
);
  localparam logic [HDR_WIDTH-1:0] MAX_LEN = HDR_WIDTH'(MAX_WORDS);
  localparam logic [HDR_WIDTH-1:0] ONE     = HDR_WIDTH'(1);

  state_t               state_q;
  logic [HDR_WIDTH-1:0] len_q;
  logic [HDR_WIDTH-1:0] wcnt_q;
  logic [HDR_WIDTH-1:0] hdr_full;
  logic [HDR_WIDTH-1:0] wcnt_nxt;
  logic                 take;
  logic                 word_done;
  logic [31:0]          word;

  // Handshake: a byte moves on a rising edge where byte_valid_i and byte_ready_o are both
  // high; byte_ready_o is registered and low outside LEN_LO/LEN_HI/DATA, so valid is ignored there.
  assign take     = byte_valid_i && byte_ready_o;
  assign hdr_full = {byte_i, len_q[7:0]};
  assign wcnt_nxt = wcnt_q + ONE;

  insn_word_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .byte_en_i   (take && (state_q == DATA)),
    .byte_i      (byte_i),
    .word_o      (word),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= LEN_LO;
      len_q            <= '0;
      wcnt_q           <= '0;
      byte_ready_o     <= 1'b0;
      insn_mem_wen_o   <= 1'b0;
      insn_mem_waddr_o <= '0;
      insn_o           <= '0;
      cpu_rstn_o       <= 1'b0;
      busy_o           <= 1'b0;
      error_o          <= 1'b0;
    end else begin
      case (state_q)
        LEN_LO: begin
          byte_ready_o <= 1'b1;
          if (take) begin
            len_q[7:0] <= byte_i;
            busy_o     <= 1'b1;
            state_q    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (take) begin
            len_q[15:8] <= byte_i;
            if (hdr_full == '0 || hdr_full > MAX_LEN) begin
              state_q          <= ERR;
              byte_ready_o     <= 1'b0;
              busy_o           <= 1'b0;
              error_o          <= 1'b1;
              insn_mem_waddr_o <= '0;
              insn_o           <= '0;
            end else begin
              state_q <= DATA;
              wcnt_q  <= '0;
            end
          end
        end
        DATA: begin
          if (word_done) begin
            state_q          <= WRITE;
            byte_ready_o     <= 1'b0;
            insn_mem_wen_o   <= 1'b1;
            insn_mem_waddr_o <= {wcnt_q[ADDR_WIDTH-3:0], 2'b00};
            insn_o           <= word;
          end
        end
        WRITE: begin
          insn_mem_wen_o <= 1'b0;
          wcnt_q         <= wcnt_nxt;
          if (wcnt_nxt == len_q) begin
            state_q    <= RUN;
            cpu_rstn_o <= 1'b1;
            busy_o     <= 1'b0;
          end else begin
            state_q      <= DATA;
            byte_ready_o <= 1'b1;
          end
        end
        RUN: begin
          if (ebreak_i) begin
            state_q      <= LEN_LO;
            cpu_rstn_o   <= 1'b0;
            byte_ready_o <= 1'b1;
          end
        end
        ERR: begin
          state_q <= ERR;
        end
        default: state_q <= ERR;
      endcase
    end
  end

  assign dbg_state_o = state_q;
endmodule
